// File: rtl/core_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the core datapath.
// Optional macro CORE_SEQ_PERF_EN adds saturating cycle/retire counters.
module core_seq #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  input  logic              stall,
  input  logic              rf_we_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              w_last;

  assign w_last = (r_pc == last_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Outputs are pure state decodes so an async reset clears them in the same cycle.
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   if (!stall) w_next = S_WB;
      S_WB: begin
        rf_we  = rf_we_req;
        w_next = w_last ? S_HALT : S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ack) r_instr <= imem_rdata;
      if (r_state == S_WB && !w_last)     r_pc    <= r_pc + 1'b1;
    end
  end

  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign instr     = r_instr;

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] r_cyc;
  logic [31:0] r_ret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT && r_cyc != 32'hFFFF_FFFF)
        r_cyc <= r_cyc + 32'd1;
      if (r_state == S_WB && r_ret != 32'hFFFF_FFFF)
        r_ret <= r_ret + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc;
  assign ret_cnt = r_ret;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed + randomized bench for core_seq; expectations come from a per-instruction
// transaction model (address k, fetched word, write strobe, 4+wait+stall cycles).
module tb_core_seq;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] last_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr;
  logic          stall;
  logic          rf_we_req;
  logic          rf_we;
  logic [AW-1:0] pc;
  logic          halted;

  logic          wr_start;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_instr;
  logic          wr_we;
  logic [AW-1:0] wr_pc;
  logic          wr_halt;

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt, wr_cyc, wr_ret;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] m_instr;
  logic [AW-1:0] wr_q[$];
  int wr_we_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_seq #(.ADDR_W(AW), .RESET_PC('0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .last_pc(last_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .stall(stall),
    .rf_we_req(rf_we_req), .rf_we(rf_we), .pc(pc), .halted(halted)
`ifdef CORE_SEQ_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // Wrap instance: memory answers in the same cycle it is asked.
  core_seq #(.ADDR_W(AW), .RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst), .start(wr_start), .last_pc(32'd1),
    .imem_req(wr_req), .imem_addr(wr_addr), .imem_ack(wr_req),
    .imem_rdata(wr_addr), .instr(wr_instr), .stall(1'b0),
    .rf_we_req(1'b1), .rf_we(wr_we), .pc(wr_pc), .halted(wr_halt)
`ifdef CORE_SEQ_PERF_EN
    , .cyc_cnt(wr_cyc), .ret_cnt(wr_ret)
`endif
  );

  always @(posedge clk) begin
    if (wr_req) wr_q.push_back(wr_addr);
    if (wr_we)  wr_we_n <= wr_we_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; stall = 1'b0;
    rf_we_req = 1'b1; last_pc = '0; imem_rdata = '0; wr_start = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_halted", halted, 0);
`ifdef CORE_SEQ_PERF_EN
    chk("rst_cyc", cyc_cnt, 0);
    chk("rst_ret", ret_cnt, 0);
`endif
    step();
    rst = 1'b0;
    m_instr = '0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("idle_req", imem_req, 0);
  endtask

  task automatic begin_prog();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One instruction from FETCH entry to the edge leaving WB.
  task automatic run_instr(input logic [AW-1:0] a, input bit last, input int w, input int s,
                           input logic [31:0] d, input logic we);
    int t0;
    t0 = cyc;
    for (int i = 0; i <= w; i++) begin
      imem_ack   = (i == w);
      imem_rdata = (i == w) ? d : $urandom;
      stall      = 1'($urandom);
      start      = 1'($urandom);
      last_pc    = $urandom;
      rf_we_req  = 1'($urandom);
      #1;
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, a);
      chk("fetch_we", rf_we, 0);
      chk("fetch_instr", instr, m_instr);
      step();
    end
    m_instr = d;
    imem_ack = 1'($urandom); imem_rdata = $urandom;
    stall = 1'($urandom); rf_we_req = 1'($urandom); start = 1'($urandom);
    #1;
    chk("dec_req", imem_req, 0);
    chk("dec_instr", instr, m_instr);
    chk("dec_we", rf_we, 0);
    step();
    for (int j = 0; j <= s; j++) begin
      stall = (j < s);
      imem_ack = 1'($urandom); imem_rdata = $urandom; rf_we_req = 1'($urandom);
      #1;
      chk("exec_we", rf_we, 0);
      chk("exec_req", imem_req, 0);
      chk("exec_instr", instr, m_instr);
      step();
    end
    rf_we_req = we;
    stall     = 1'($urandom);
    imem_ack  = 1'($urandom);
    last_pc   = last ? a : a + 32'd1 + AW'($urandom_range(0, 100));
    #1;
    chk("wb_we", rf_we, we);
    chk("wb_pc", pc, a);
    chk("wb_instr", instr, m_instr);
    step();
    imem_ack = 1'b0; stall = 1'b0; start = 1'b0; last_pc = $urandom;
    chk("instr_cycles", cyc - t0, 4 + w + s);
  endtask

  task automatic check_halt(input logic [AW-1:0] exp_pc);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; imem_ack = 1'b1; rf_we_req = 1'b1; last_pc = $urandom;
      #1;
      chk("halt_flag", halted, 1);
      chk("halt_pc", pc, exp_pc);
      chk("halt_req", imem_req, 0);
      chk("halt_we", rf_we, 0);
      step();
    end
    start = 1'b0; imem_ack = 1'b0;
  endtask

  initial begin
    int t0, n;
    logic [AW-1:0] wexp[3];
    wexp[0] = 32'hFFFF_FFFF; wexp[1] = 32'd0; wexp[2] = 32'd1;

    // Address wrap: FFFFFFFF, 0, 1 then HALT.
    do_reset();
    wr_q.delete();
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    repeat (15) step();
    chk("wrap_count", wr_q.size(), 3);
    for (int i = 0; i < wr_q.size() && i < 3; i++) chk("wrap_addr", wr_q[i], wexp[i]);
    chk("wrap_halt", wr_halt, 1);
    chk("wrap_pc", wr_pc, 1);
    chk("wrap_we_n", wr_we_n, 3);

    // Three zero-wait instructions in 12 cycles.
    do_reset();
    begin_prog();
    t0 = cyc;
    run_instr(0, 0, 0, 0, $urandom, 1);
    run_instr(1, 0, 0, 0, $urandom, 1);
    run_instr(2, 1, 0, 0, $urandom, 1);
    chk("c1_cycles", cyc - t0, 12);
`ifdef CORE_SEQ_PERF_EN
    chk("c1_ret", ret_cnt, 3);
    chk("c1_cyc", cyc_cnt, 12);
`endif
    check_halt(2);
`ifdef CORE_SEQ_PERF_EN
    chk("halt_cyc_frozen", cyc_cnt, 12);
`endif

    // Ack delay, long stall, write-enable gating.
    do_reset();
    begin_prog();
    run_instr(0, 0, 0, 1, 32'h1111_0000, 1);
    run_instr(1, 0, 3, 0, 32'h2222_0001, 0);
    run_instr(2, 0, 0, 5, 32'h3333_0002, 1);
    run_instr(3, 1, 1, 2, 32'h4444_0003, 0);
    check_halt(3);

    // Randomized programs.
    repeat (4) begin
      do_reset();
      n = $urandom_range(1, 6);
      begin_prog();
      for (int k = 0; k < n; k++)
        run_instr(AW'(k), k == n - 1, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom, 1'($urandom));
      check_halt(AW'(n - 1));
    end

    // Reset mid-FETCH with an ack pending.
    do_reset();
    begin_prog();
    run_instr(0, 0, 0, 0, 32'hAAAA_5555, 1);
    imem_ack = 1'b0; rf_we_req = 1'b1;
    #1;
    chk("mf_req_before", imem_req, 1);
    #3;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("mf_req", imem_req, 0);
    chk("mf_pc", pc, 0);
    chk("mf_instr", instr, 0);
    chk("mf_halted", halted, 0);
    step();
    rst = 1'b0;
    step();
    imem_ack = 1'b0;
    chk("mf_idle_req", imem_req, 0);
    chk("mf_idle_instr", instr, 0);

    // Reset mid-EXEC.
    begin_prog();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0; stall = 1'b1;
    step();
    step();
    chk("me_instr_before", instr, 32'h1234_5678);
    #2;
    rst = 1'b1;
    #1;
    chk("me_req", imem_req, 0);
    chk("me_pc", pc, 0);
    chk("me_instr", instr, 0);
    chk("me_we", rf_we, 0);
    chk("me_halted", halted, 0);
    step();
    rst = 1'b0; stall = 1'b0;
    step();
    chk("me_idle_req", imem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
